// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the memory arbiter.
interface mem_arbiter_if #(parameter int WIDTH = 32, parameter int ADDR = 10);
  logic             i_req;
  logic [ADDR-1:0]  i_addr;
  logic             i_gnt;
  logic             i_rvalid;
  logic [WIDTH-1:0] i_rdata;
  logic             d_req;
  logic [ADDR-1:0]  d_addr;
  logic [3:0]       d_we;
  logic [WIDTH-1:0] d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [WIDTH-1:0] d_rdata;
  logic             mem_en;
  logic [ADDR-1:0]  mem_addr;
  logic [3:0]       mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             stall_f;
  logic             stall_m;
  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_addr, mem_we, mem_wdata, stall_f, stall_m
  );
  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_addr, mem_we, mem_wdata, stall_f, stall_m
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter for fetch/data ports, data priority with fetch starvation guard.
// Define MEM_ARBITER_RR_EN to alternate winners on contention instead of fixed data priority.
module mem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int ADDR     = 10,
  parameter int MAX_WAIT = 4
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;
  owner_t        r_owner;
  logic          r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_force;
  logic          w_i_win;
  logic          w_i_gnt;
  logic          w_d_gnt;
  logic          w_i_rv;
  logic          w_d_rv;
  assign w_force = bus.i_req && r_cnt == CW'(MAX_WAIT);
`ifdef MEM_ARBITER_RR_EN
  logic r_last_d;
  assign w_i_win = !bus.d_req || w_force || r_last_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_last_d <= 1'b0;
    else if (bus.i_req && bus.d_req) r_last_d <= w_d_gnt;
`else
  assign w_i_win = !bus.d_req || w_force;
`endif
  // grants are held low for the whole reset so stalls mirror requests
  assign w_i_gnt = !reset && bus.i_req && w_i_win;
  assign w_d_gnt = !reset && bus.d_req && !w_i_gnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_owner <= OWN_NONE;
      r_rd    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_owner <= w_i_gnt ? OWN_I : w_d_gnt ? OWN_D : OWN_NONE;
      r_rd    <= w_d_gnt && bus.d_we == 4'd0;
      r_cnt   <= (bus.i_req && !w_i_gnt) ? (w_force ? r_cnt : CW'(r_cnt + 1'b1)) : '0;
    end
  assign w_i_rv        = r_owner == OWN_I;
  assign w_d_rv        = r_owner == OWN_D && r_rd;
  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_en    = w_i_gnt || w_d_gnt;
  assign bus.mem_addr  = w_i_gnt ? bus.i_addr : w_d_gnt ? bus.d_addr : ADDR'(0);
  assign bus.mem_we    = w_d_gnt ? bus.d_we : 4'd0;
  assign bus.mem_wdata = w_d_gnt ? bus.d_wdata : WIDTH'(0);
  assign bus.i_rvalid  = w_i_rv;
  assign bus.d_rvalid  = w_d_rv;
  assign bus.i_rdata   = w_i_rv ? bus.mem_rdata : WIDTH'(0);
  assign bus.d_rdata   = w_d_rv ? bus.mem_rdata : WIDTH'(0);
  assign bus.stall_f   = bus.i_req && !w_i_gnt;
  assign bus.stall_m   = bus.d_req && !w_d_gnt;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter against a policy-level reference model.
module tb_mem_arbiter;
  localparam int W  = 32;
  localparam int A  = 10;
  localparam int MW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_arbiter_if #(.WIDTH(W), .ADDR(A)) b ();
  mem_arbiter #(.WIDTH(W), .ADDR(A), .MAX_WAIT(MW)) dut (.clk(clk), .reset(reset), .bus(b));
  logic [W-1:0] mem [256];
  logic [W-1:0] ref_mem [256];
  int nchk = 0;
  int nbad = 0;
  int cnt = 0;
  bit last_d = 1'b0;
  int pend = 0;
  logic [W-1:0] pend_data = '0;
  always @(posedge clk)
    if (b.mem_en) begin
      if (b.mem_we == 4'd0) b.mem_rdata <= mem[b.mem_addr[A-1:2]];
      else for (int k = 0; k < 4; k++) if (b.mem_we[k]) mem[b.mem_addr[A-1:2]][8*k +: 8] <= b.mem_wdata[8*k +: 8];
    end
  task automatic model_reset();
    cnt = 0;
    last_d = 1'b0;
    pend = 0;
  endtask
  task automatic step(input string tag, input bit ir, input logic [A-1:0] ia, input bit dr,
                      input logic [A-1:0] da, input logic [3:0] dw, input logic [W-1:0] dd);
    bit eig, edg;
    logic [4:0] ectl;
    logic [A-1:0] ea;
    b.i_req = ir; b.i_addr = ia; b.d_req = dr; b.d_addr = da; b.d_we = dw; b.d_wdata = dd;
`ifdef MEM_ARBITER_RR_EN
    eig = ir && (!dr || cnt == MW || last_d);
`else
    eig = ir && (!dr || cnt == MW);
`endif
    edg = dr && !eig;
    ectl = {eig, edg, eig | edg, ir && !eig, dr && !edg};
    ea = eig ? ia : edg ? da : '0;
    #4;
    nchk++;
    if ({b.i_gnt, b.d_gnt, b.mem_en, b.stall_f, b.stall_m} !== ectl) begin
      nbad++;
      $display("FAIL %s ctrl(i_gnt,d_gnt,mem_en,stall_f,stall_m) got %b want %b", tag, {b.i_gnt, b.d_gnt, b.mem_en, b.stall_f, b.stall_m}, ectl);
    end
    nchk++;
    if ({b.mem_addr, b.mem_we, b.mem_wdata} !== {ea, edg ? dw : 4'd0, edg ? dd : {W{1'b0}}}) begin
      nbad++;
      $display("FAIL %s membus addr/we/wdata got %h/%h/%h want %h/%h/%h", tag, b.mem_addr, b.mem_we, b.mem_wdata, ea, edg ? dw : 4'd0, edg ? dd : {W{1'b0}});
    end
    nchk++;
    if ({b.i_rvalid, b.d_rvalid, b.i_rdata, b.d_rdata} !== {pend == 1, pend == 2, pend == 1 ? pend_data : {W{1'b0}}, pend == 2 ? pend_data : {W{1'b0}}}) begin
      nbad++;
      $display("FAIL %s rsp i_rv/d_rv/i_rdata/d_rdata got %b/%b/%h/%h want %b/%b/%h/%h", tag, b.i_rvalid, b.d_rvalid, b.i_rdata, b.d_rdata,
               pend == 1, pend == 2, pend == 1 ? pend_data : {W{1'b0}}, pend == 2 ? pend_data : {W{1'b0}});
    end
    if (ir && dr) last_d = edg;
    cnt = (ir && !eig) ? (cnt < MW ? cnt + 1 : MW) : 0;
    pend_data = ref_mem[ea[A-1:2]];
    pend = eig ? 1 : (edg && dw == 4'd0) ? 2 : 0;
    if (edg) for (int k = 0; k < 4; k++) if (dw[k]) ref_mem[da[A-1:2]][8*k +: 8] = dd[8*k +: 8];
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input string tag);
    step(tag, 1'b0, '0, 1'b0, '0, 4'd0, '0);
  endtask
  task automatic test_reset();
    @(posedge clk);
    #1;
    b.i_req = 1'b1; b.d_req = 1'b1; b.i_addr = 10'h010; b.d_addr = 10'h100; b.d_we = 4'hf; b.d_wdata = 32'h1234_5678;
    #4;
    nchk++;
    if ({b.i_gnt, b.d_gnt, b.mem_en, b.stall_f, b.stall_m, b.i_rvalid, b.d_rvalid} !== 7'b0001100) begin
      nbad++;
      $display("FAIL rst_both gnt/en/stall/rv got %b want %b", {b.i_gnt, b.d_gnt, b.mem_en, b.stall_f, b.stall_m, b.i_rvalid, b.d_rvalid}, 7'b0001100);
    end
    nchk++;
    if ({b.mem_addr, b.mem_we, b.mem_wdata, b.i_rdata, b.d_rdata} !== '0) begin
      nbad++;
      $display("FAIL rst_bus addr/we/wdata got %h/%h/%h want 0", b.mem_addr, b.mem_we, b.mem_wdata);
    end
    b.d_req = 1'b0;
    #1;
    nchk++;
    if ({b.stall_f, b.stall_m} !== 2'b10) begin
      nbad++;
      $display("FAIL rst_stall got %b want %b", {b.stall_f, b.stall_m}, 2'b10);
    end
    @(posedge clk);
    #1;
    b.i_req = 1'b0;
    reset = 1'b0;
    model_reset();
  endtask
  task automatic test_fetch();
    step("fetch", 1'b1, 10'h010, 1'b0, '0, 4'd0, '0);
    idle("fetch_rsp");
    nchk++;
    if (ref_mem[4] !== 32'h0000_0013) begin
      nbad++;
      $display("FAIL fetch_word got %h want %h", ref_mem[4], 32'h0000_0013);
    end
  endtask
  task automatic test_contention();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 5; c++) step($sformatf("both_r%0d_c%0d", r, c), 1'b1, 10'h010, 1'b1, 10'h100, 4'd0, '0);
    idle("both_rsp");
  endtask
  task automatic test_store();
    step("store", 1'b0, '0, 1'b1, 10'h104, 4'b0011, 32'hDEAD_BEEF);
    step("store_load", 1'b0, '0, 1'b1, 10'h104, 4'd0, '0);
    idle("store_rsp");
  endtask
  task automatic test_reset_mid();
    b.i_req = 1'b1; b.i_addr = 10'h010; b.d_req = 1'b0; b.d_we = 4'd0;
    #4;
    nchk++;
    if (b.i_gnt !== 1'b1) begin
      nbad++;
      $display("FAIL midrst_gnt got %b want 1", b.i_gnt);
    end
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle("midrst_rsp");
    for (int c = 0; c < 5; c++) step($sformatf("midrst_both_c%0d", c), 1'b1, 10'h020, 1'b1, 10'h104, 4'd0, '0);
    idle("midrst_tail");
  endtask
  task automatic test_back_to_back();
    for (int c = 0; c < 8; c++)
      step($sformatf("b2b_%0d", c), c % 2 == 0, 10'(4 * c), c % 2 == 1, 10'(4 * c + 64), 4'd0, '0);
    idle("b2b_tail");
  endtask
  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      logic [3:0] we;
      we = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      step($sformatf("rnd_%0d", c), $urandom_range(0, 3) != 0, 10'($urandom), $urandom_range(0, 3) != 0, 10'($urandom), we, $urandom);
    end
    idle("rnd_tail");
  endtask
  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k] = 32'hA5A5_0000 ^ (k * 32'h0101_0003);
      ref_mem[k] = mem[k];
    end
    mem[4] = 32'h0000_0013;
    ref_mem[4] = 32'h0000_0013;
    b.i_req = 1'b0; b.i_addr = '0; b.d_req = 1'b0; b.d_addr = '0; b.d_we = 4'd0; b.d_wdata = '0;
    b.mem_rdata = '0;
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
